alu_mb_seq: RTL and testbench
=============================

# alu_mb_seq

Multi-byte arithmetic sequencer that drives the 8-bit ALU datapath one byte per cycle to perform NBYTES-wide ADD, SUB, shift-left and shift-right operations. It is the instruction-issuing side of the ALU decoder: it generates the opcode byte `d` and the carry flag `fl_carry`, and selects operand bytes through `idx`. It consumes the ALU result and the `pre_carry`, `pre_z` and `pre_lt` flags, writes result bytes out and reports the final flags.

## Interface
- NBYTES, 4, operand width in bytes (≥1)
- AW, 2, index width, ≥ clog2(NBYTES), min 1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 SHL, 11 SHR; sampled with start
- start_chain  in  1  1 = first byte also consumes `fl_carry` (multi-word continuation); sampled with start
- d  out  8  opcode byte to ALU decoder
- fl_carry  out  1  carry flag register, feeds decoder
- idx  out  AW  operand byte index; external mux presents `a_direct`/`b_direct`
- alu_o  in  8  ALU result byte
- pre_carry, pre_z, pre_lt  in  1 each  ALU combinational flags
- res_we  out  1  result byte write strobe
- res_idx  out  AW  result byte index (= idx)
- res_data  out  8  result byte (= alu_o)
- busy  out  1  high in RUN and FIN
- done  out  1  one-cycle pulse in FIN
- flag_c, flag_z, flag_n  out  1 each  final flags of the last operation

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE→RUN when start=1: latch op and chain; set cnt=0; load idx (0, or NBYTES-1 for SHR).
  - RUN stays for NBYTES cycles.
  - RUN→FIN after the byte with cnt=NBYTES-1.
  - FIN→IDLE unconditionally.
- Byte order:
  - ADD, SUB, SHL: idx 0→NBYTES-1 (LSB first).
  - SHR: idx NBYTES-1→0 (MSB first).
- Opcode encoding. "first" means cnt=0 and chain=0; otherwise the chained form applies.
  - ADD: 0x20 first / 0xA0 chained.
  - SUB: 0x60 first (decoder forces carry-in) / 0xE0 chained.
  - SHL: 0x08 / 0x88.
  - SHR: 0x18 / 0x98.
  - Bits 2:0 are always 0.
  - In IDLE and FIN, d=0x00.
- Combinational outputs:
  - res_we=1 exactly during RUN cycles.
  - res_data=alu_o.
  - res_idx=idx.
- Per RUN edge:
  - fl_carry<=pre_carry.
  - z_acc<=(cnt==0 ? 1 : z_acc) & pre_z.
  - If idx==NBYTES-1: n_acc<=pre_lt.
  - idx steps ±1; cnt+1.
- FIN edge: flag_c<=fl_carry; flag_z<=z_acc; flag_n<=n_acc.
- SUB carry convention: carry=1 means no borrow.
- fl_carry holds its value outside RUN.
- start asserted in RUN or FIN is ignored; no queuing.
- NBYTES=1: the single byte is both first and MSB.

## Timing
- Reset (async) values:
  - State IDLE.
  - d=0x00; fl_carry=0; idx=0; cnt=0.
  - res_we=0; busy=0; done=0.
  - flag_c=0; flag_z=0; flag_n=0.
- Reset mid-RUN aborts immediately: no further res_we; previously written bytes are not undone.
- Start accepted at edge k:
  - RUN occupies cycles k+1 … k+NBYTES.
  - FIN (done=1) occupies cycle k+NBYTES+1.
  - Final flags are valid from edge k+NBYTES+1 onward.
- Earliest next start: sampled during the first IDLE cycle after FIN.
  - Throughput: one operation per NBYTES+2 cycles.
- The ALU is combinational. alu_o and pre_* must settle within the same RUN cycle that d and idx are presented.

## Test plan
1. **ADD, carry across bytes.** NBYTES=4; ADD 0x000000FF+0x00000001.
   - d=20,A0,A0,A0; idx=0,1,2,3.
   - res bytes 00,01,00,00.
   - done in cycle 5 after start; flag_c=0, flag_z=0, flag_n=0.
2. **SUB with borrow.** 0x00000001−0x00000002.
   - d=60,E0,E0,E0.
   - res FF,FF,FF,FF; flag_c=0, flag_n=1, flag_z=0.
3. **SUB to zero.** 0x12345678−0x12345678.
   - res all 00; flag_z=1, flag_c=1, flag_n=0.
4. **SHR, MSB first.** 0x80000001.
   - idx=3,2,1,0; d=18,98,98,98.
   - res 40,00,00,00 written to idx 3,2,1,0.
   - flag_c=1, flag_n=0.
5. **Chained ADD.** Preload flag_c=1 via 0xFFFFFFFF+1, then start_chain=1 ADD 0+0.
   - First d=A0.
   - Result 0x00000001; flag_z=0.
6. **Reset and start rejection.**
   - Start pulses during RUN/FIN are ignored; no second done.
   - rst asserted after the 2nd RUN cycle: next sample busy=0, res_we=0, d=00, all flags 0, state IDLE.
   - A new start then runs normally.

Source files
------------

// File: rtl/alu_mb_seq.sv
// alu_mb_seq: multi-byte arithmetic sequencer.
// Drives an external 8-bit ALU one byte per cycle to perform NBYTES-wide
// ADD, SUB, SHL and SHR operations, then reports the final C/Z/N flags.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, op, start_chain   operation request (sampled only in IDLE)
//   d                        opcode byte to the ALU decoder
//   fl_carry                 carry flag register feeding the decoder
//   idx                      operand byte index for the external operand mux
//   alu_o, pre_carry,
//   pre_z, pre_lt            ALU result byte and combinational flags
//   res_we, res_idx,
//   res_data                 result byte write port
//   busy, done               status (busy in RUN/FIN, done pulses in FIN)
//   flag_c, flag_z, flag_n   final flags of the last operation
module alu_mb_seq #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned AW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          start_chain,
    output logic [7:0]    d,
    output logic          fl_carry,
    output logic [AW-1:0] idx,
    input  logic [7:0]    alu_o,
    input  logic          pre_carry,
    input  logic          pre_z,
    input  logic          pre_lt,
    output logic          res_we,
    output logic [AW-1:0] res_idx,
    output logic [7:0]    res_data,
    output logic          busy,
    output logic          done,
    output logic          flag_c,
    output logic          flag_z,
    output logic          flag_n
);

    localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(NBYTES - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    // First-byte opcodes; bit 7 selects the chained (carry-consuming) form.
    localparam logic [7:0] OPC_ADD   = 8'h20;
    localparam logic [7:0] OPC_SUB   = 8'h60;
    localparam logic [7:0] OPC_SHL   = 8'h08;
    localparam logic [7:0] OPC_SHR   = 8'h18;
    localparam logic [7:0] OPC_CHAIN = 8'h80;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

    state_e        state_q, state_d;

    logic [1:0]    op_q, op_d;
    logic          chain_q, chain_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          fl_carry_q, fl_carry_d;
    logic          z_acc_q, z_acc_d;
    logic          n_acc_q, n_acc_d;
    logic          flag_c_q, flag_c_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_n_q, flag_n_d;

    logic          first_byte;
    logic [7:0]    opc_base;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (cnt_q == LAST_CNT) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: operation latch, byte stepping, flag accumulation.
    always_comb begin
        op_d       = op_q;
        chain_d    = chain_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        fl_carry_d = fl_carry_q;
        z_acc_d    = z_acc_q;
        n_acc_d    = n_acc_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    chain_d = start_chain;
                    cnt_d   = '0;
                    // SHR walks MSB first so the shifted-out bit ripples down.
                    idx_d   = (op == OP_SHR) ? LAST_IDX : '0;
                end
            end
            S_RUN: begin
                fl_carry_d = pre_carry;
                z_acc_d    = ((cnt_q == '0) ? 1'b1 : z_acc_q) & pre_z;
                // Sign comes from whichever cycle handles the MSB byte.
                if (idx_q == LAST_IDX) begin
                    n_acc_d = pre_lt;
                end
                idx_d = (op_q == OP_SHR) ? (idx_q - AW'(1)) : (idx_q + AW'(1));
                cnt_d = cnt_q + CW'(1);
            end
            S_FIN: begin
                flag_c_d = fl_carry_q;
                flag_z_d = z_acc_q;
                flag_n_d = n_acc_q;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_ADD;
            chain_q    <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            fl_carry_q <= 1'b0;
            z_acc_q    <= 1'b0;
            n_acc_q    <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else begin
            op_q       <= op_d;
            chain_q    <= chain_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            fl_carry_q <= fl_carry_d;
            z_acc_q    <= z_acc_d;
            n_acc_q    <= n_acc_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
        end
    end

    // Output decode from the current state.
    always_comb begin
        d          = 8'h00;
        busy       = 1'b0;
        done       = 1'b0;
        res_we     = 1'b0;
        first_byte = 1'b0;
        opc_base   = 8'h00;

        case (op_q)
            OP_ADD:  opc_base = OPC_ADD;
            OP_SUB:  opc_base = OPC_SUB;
            OP_SHL:  opc_base = OPC_SHL;
            OP_SHR:  opc_base = OPC_SHR;
            default: opc_base = 8'h00;
        endcase

        case (state_q)
            S_RUN: begin
                busy       = 1'b1;
                res_we     = 1'b1;
                // Only an unchained first byte uses the carry-initialising form.
                first_byte = (cnt_q == '0) && !chain_q;
                d          = first_byte ? opc_base : (opc_base | OPC_CHAIN);
            end
            S_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign idx      = idx_q;
    assign res_idx  = idx_q;
    assign res_data = alu_o;
    assign fl_carry = fl_carry_q;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;
    assign flag_n   = flag_n_q;

endmodule

// File: tb/tb_alu_mb_seq.sv
// Self-checking bench for alu_mb_seq: models the external 8-bit ALU and the
// operand byte mux, and checks every operation against a whole-word model.
module tb_alu_mb_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned W  = NB * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic          start_chain;
    logic [7:0]    d;
    logic          fl_carry;
    logic [AW-1:0] idx;
    logic [7:0]    alu_res;
    logic          pre_c, pz, plt;
    logic          res_we;
    logic [AW-1:0] res_idx;
    logic [7:0]    res_data;
    logic          busy, done;
    logic          flag_c, flag_z, flag_n;

    logic [W-1:0]  a_mem, b_mem;
    logic          model_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_mb_seq #(.NBYTES(NB), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .start_chain(start_chain),
        .d(d), .fl_carry(fl_carry), .idx(idx),
        .alu_o(alu_res), .pre_carry(pre_c), .pre_z(pz), .pre_lt(plt),
        .res_we(res_we), .res_idx(res_idx), .res_data(res_data),
        .busy(busy), .done(done),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n)
    );

    // External combinational ALU + operand mux.
    logic [7:0] a_byte, b_byte;
    logic       alu_cin;
    logic [8:0] sum9;
    always_comb begin
        a_byte  = a_mem[int'(idx)*8 +: 8];
        b_byte  = b_mem[int'(idx)*8 +: 8];
        alu_cin = d[7] ? fl_carry : d[6];
        sum9    = '0;
        alu_res = '0;
        pre_c   = 1'b0;
        if (d[5]) begin
            sum9    = {1'b0, a_byte} + {1'b0, (d[6] ? ~b_byte : b_byte)} + {8'h00, alu_cin};
            alu_res = sum9[7:0];
            pre_c   = sum9[8];
        end else if (d[3]) begin
            if (d[4]) begin
                alu_res = {alu_cin, a_byte[7:1]};
                pre_c   = a_byte[0];
            end else begin
                alu_res = {a_byte[6:0], alu_cin};
                pre_c   = a_byte[7];
            end
        end
        pz  = (alu_res == 8'h00);
        plt = alu_res[7];
    end

    // Run one whole operation and check every cycle; poke=1 hammers start
    // with a different op during RUN and FIN, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic ch,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke, input string tag);
        logic [W:0]    wide;
        logic          cin;
        logic [W-1:0]  exp_res, got;
        logic          exp_c, exp_z, exp_n;
        logic [7:0]    base, exp_d;
        logic [AW-1:0] exp_idx;

        case (o)
            2'd0: begin cin = ch ? model_c : 1'b0;
                        wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; end
            2'd1: begin cin = ch ? model_c : 1'b1;
                        wide = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin}; end
            2'd2: begin cin = ch ? model_c : 1'b0;
                        wide = {a, cin}; end
            default: begin cin = ch ? model_c : 1'b0;
                        wide = {a[0], cin, a[W-1:1]}; end
        endcase
        exp_res = wide[W-1:0];
        exp_c   = wide[W];
        exp_z   = (exp_res == '0);
        exp_n   = exp_res[W-1];
        case (o)
            2'd0: base = 8'h20;
            2'd1: base = 8'h60;
            2'd2: base = 8'h08;
            default: base = 8'h18;
        endcase

        a_mem = a; b_mem = b; op = o; start_chain = ch; start = 1'b1;
        @(negedge clk);
        start = poke;
        got = '0;
        for (int i = 0; i < int'(NB); i++) begin
            exp_idx = (o == 2'd3) ? AW'(int'(NB) - 1 - i) : AW'(i);
            exp_d   = (i == 0 && !ch) ? base : (base | 8'h80);
            n_checks++;
            if (busy !== 1'b1 || res_we !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s run_status byte%0d: busy=%b we=%b done=%b, want 1 1 0", tag, i, busy, res_we, done);
            end
            n_checks++;
            if (d !== exp_d) begin
                n_errors++;
                $display("FAIL %s opcode byte%0d: got %h want %h", tag, i, d, exp_d);
            end
            n_checks++;
            if (idx !== exp_idx || res_idx !== exp_idx) begin
                n_errors++;
                $display("FAIL %s idx byte%0d: idx=%0d res_idx=%0d want %0d", tag, i, idx, res_idx, exp_idx);
            end
            got[int'(res_idx)*8 +: 8] = res_data;
            if (poke) begin op = ~o; start_chain = ~ch; start = 1'b1; end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || res_we !== 1'b0 || d !== 8'h00) begin
            n_errors++;
            $display("FAIL %s fin: done=%b busy=%b we=%b d=%h want 1 1 0 00", tag, done, busy, res_we, d);
        end
        @(negedge clk);
        start = 1'b0; op = o; start_chain = ch;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle: done=%b busy=%b want 0 0", tag, done, busy);
        end
        n_checks++;
        if (got !== exp_res) begin
            n_errors++;
            $display("FAIL %s result: got %h want %h", tag, got, exp_res);
        end
        n_checks++;
        if (flag_c !== exp_c || flag_z !== exp_z || flag_n !== exp_n || fl_carry !== exp_c) begin
            n_errors++;
            $display("FAIL %s flags: c=%b z=%b n=%b fl=%b want c=%b z=%b n=%b", tag,
                     flag_c, flag_z, flag_n, fl_carry, exp_c, exp_z, exp_n);
        end
        model_c = exp_c;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'd0; start_chain = 1'b0;
        a_mem = '0; b_mem = '0; model_c = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || res_we !== 1'b0 || d !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_status: busy=%b done=%b we=%b d=%h want 0 0 0 00", busy, done, res_we, d);
        end
        n_checks++;
        if (fl_carry !== 1'b0 || idx !== '0 || flag_c !== 1'b0 || flag_z !== 1'b0 || flag_n !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs: fl=%b idx=%0d c=%b z=%b n=%b want all 0", fl_carry, idx, flag_c, flag_z, flag_n);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || res_we !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: busy=%b we=%b want 0 0", busy, res_we);
        end
    endtask

    task automatic test_add();
        run_op(2'd0, 1'b0, 32'h000000FF, 32'h00000001, 1'b0, "add_carry");
        for (int i = 0; i < 6; i++) run_op(2'd0, 1'b0, $urandom, $urandom, 1'b0, "add_rand");
    endtask

    task automatic test_sub();
        run_op(2'd1, 1'b0, 32'h00000001, 32'h00000002, 1'b0, "sub_borrow");
        run_op(2'd1, 1'b0, 32'h12345678, 32'h12345678, 1'b0, "sub_zero");
        for (int i = 0; i < 6; i++) run_op(2'd1, 1'b0, $urandom, $urandom, 1'b0, "sub_rand");
    endtask

    task automatic test_shift();
        run_op(2'd3, 1'b0, 32'h80000001, 32'h0, 1'b0, "shr_msb_first");
        run_op(2'd2, 1'b0, 32'h80000001, 32'h0, 1'b0, "shl_edge");
        for (int i = 0; i < 6; i++) run_op(2'($urandom_range(2, 3)), 1'b0, $urandom, $urandom, 1'b0, "shift_rand");
    endtask

    task automatic test_chain();
        run_op(2'd0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, "chain_preload");
        run_op(2'd0, 1'b1, 32'h00000000, 32'h00000000, 1'b0, "chain_add");
        for (int i = 0; i < 8; i++) run_op(2'($urandom_range(0, 3)), 1'b1, $urandom, $urandom, 1'b0, "chain_rand");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++)
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, "b2b");
    endtask

    task automatic test_start_ignored();
        run_op(2'd1, 1'b0, $urandom, $urandom, 1'b1, "start_poke");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || res_we !== 1'b0) begin
                n_errors++;
                $display("FAIL no_queued_op cyc%0d: busy=%b done=%b we=%b want 0 0 0", i, busy, done, res_we);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        run_op(2'd0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, "pre_abort");
        a_mem = $urandom; b_mem = $urandom; op = 2'd0; start_chain = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || res_we !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_precond: busy=%b we=%b want 1 1", busy, res_we);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || res_we !== 1'b0 || d !== 8'h00 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_status: busy=%b we=%b d=%h done=%b want 0 0 00 0", busy, res_we, d, done);
        end
        n_checks++;
        if (flag_c !== 1'b0 || flag_z !== 1'b0 || flag_n !== 1'b0 || fl_carry !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_flags: c=%b z=%b n=%b fl=%b want 0 0 0 0", flag_c, flag_z, flag_n, fl_carry);
        end
        @(negedge clk);
        n_checks++;
        if (res_we !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_hold: we=%b busy=%b want 0 0", res_we, busy);
        end
        rst = 1'b0;
        model_c = 1'b0;
        @(negedge clk);
        run_op(2'd1, 1'b0, $urandom, $urandom, 1'b0, "after_abort");
        run_op(2'd0, 1'b1, $urandom, $urandom, 1'b0, "after_abort_chain");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_chain();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
